// File: rtl/gray_seq_if.sv
// gray_seq_if
//   Host-side bundle for the Gray sequencer run controller.
//   master : host (drives start/stop/pause/dir/steps, observes status and code)
//   slave  : gray_seq_ctrl (observes commands, drives code and status)
//   Signals:
//     start, stop, pause, dir  : 1-bit commands
//     steps [CNTW]             : run length in Gray advances
//     gray, bin [WIDTH]        : registered Gray code and its binary equivalent
//     busy, done, aborted, wrap: run status
interface gray_seq_if #(
    parameter int WIDTH = 2,
    parameter int CNTW  = 8
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic [CNTW-1:0]  steps;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             wrap;

    modport master (
        output start, stop, pause, dir, steps,
        input  gray, bin, busy, done, aborted, wrap
    );

    modport slave (
        input  start, stop, pause, dir, steps,
        output gray, bin, busy, done, aborted, wrap
    );
endinterface

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Run controller owning a WIDTH-bit Gray counter. A start command latches a
//   step count and direction; the code then advances one step per clock until
//   the count is exhausted, with pause (hold) and stop (abort) support.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-low reset
//     bus   : gray_seq_if.slave (commands in, Gray/binary code and status out)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; stop/pause ignored
//   RUN   | advancing one code per clock (stop > pause > advance)
//   HOLD  | paused; code and remaining count frozen
//   DONE  | one-cycle completion pulse, then back to IDLE
module gray_seq_ctrl #(
    parameter int WIDTH = 2,
    parameter int CNTW  = 8
) (
    input  logic       clk,
    input  logic       reset,
    gray_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNTW-1:0]  remaining, remaining_nx;
    logic             dir_r, dir_nx;
    logic [WIDTH-1:0] bin_r, bin_nx;
    logic [WIDTH-1:0] gray_r;
    logic             aborted_r, aborted_nx;
    logic             wrap_r, wrap_nx;

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        dir_nx       = dir_r;
        bin_nx       = bin_r;
        aborted_nx   = 1'b0;
        wrap_nx      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    remaining_nx = bus.steps;
                    dir_nx       = bus.dir;
                    state_nx     = (bus.steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nx   = ST_IDLE;
                    aborted_nx = 1'b1;
                end else if (bus.pause) begin
                    state_nx = ST_HOLD;
                end else begin
                    if (dir_r) begin
                        bin_nx  = bin_r - 1'b1;
                        wrap_nx = (bin_r == '0);
                    end else begin
                        bin_nx  = bin_r + 1'b1;
                        wrap_nx = &bin_r;
                    end
                    remaining_nx = remaining - 1'b1;
                    if (remaining == CNTW'(1))
                        state_nx = ST_DONE;
                end
            end
            ST_HOLD: begin
                if (bus.stop) begin
                    state_nx   = ST_IDLE;
                    aborted_nx = 1'b1;
                end else if (!bus.pause) begin
                    // No advance on the resume edge; counting restarts next edge.
                    state_nx = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            dir_r     <= 1'b0;
            bin_r     <= '0;
            gray_r    <= '0;
            aborted_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            dir_r     <= dir_nx;
            bin_r     <= bin_nx;
            // Gray is registered from the next binary value so both update on
            // the same edge and no intermediate code is ever stored.
            gray_r    <= bin_nx ^ (bin_nx >> 1);
            aborted_r <= aborted_nx;
            wrap_r    <= wrap_nx;
        end
    end

    assign bus.gray    = gray_r;
    assign bus.bin     = bin_r;
    assign bus.busy    = (state == ST_RUN) || (state == ST_HOLD);
    assign bus.done    = (state == ST_DONE);
    assign bus.aborted = aborted_r;
    assign bus.wrap    = wrap_r;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl
//   Per-cycle vector table for gray_seq_ctrl (WIDTH=2, CNTW=8). Each record
//   holds the inputs applied before a clock edge and the outputs expected
//   after it; expectations are queued when driven and popped after the edge.
module tb_gray_seq_ctrl;

    localparam int WIDTH = 2;
    localparam int CNTW  = 8;

    typedef struct {
        logic             rst;
        logic             start;
        logic             stop;
        logic             pause;
        logic             dir;
        logic [CNTW-1:0]  steps;
        logic [WIDTH-1:0] gray;
        logic [WIDTH-1:0] bin;
        logic             busy;
        logic             done;
        logic             aborted;
        logic             wrap;
    } vec_t;

    logic clk;
    logic reset;

    gray_seq_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    gray_seq_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic rst, logic start, logic stop, logic pause,
                                logic dir, int steps, logic [1:0] gray, int bin,
                                logic busy, logic done, logic aborted, logic wrap);
        vec_t v;
        v.rst = rst; v.start = start; v.stop = stop; v.pause = pause; v.dir = dir;
        v.steps = CNTW'(steps);
        v.gray = gray; v.bin = WIDTH'(bin);
        v.busy = busy; v.done = done; v.aborted = aborted; v.wrap = wrap;
        return v;
    endfunction

    initial begin
        vec_t       e;
        vec_t       v;
        logic [1:0] prev_gray;
        logic [1:0] diff;

        //                rst st sp pa dr stp   gray   bin bsy dn ab wr
        // reset, including start held during reset
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4,  2'b00, 0, 0, 0, 0, 0));
        // up, 4 steps, wrap on final advance
        vecs.push_back(mk(1, 1, 0, 0, 0, 4,  2'b00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b11, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0, 0));
        // down, 3 steps, wrap on first advance; dir released after start
        vecs.push_back(mk(1, 1, 0, 0, 1, 3,  2'b00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b11, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b01, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b01, 1, 0, 0, 0, 0));
        // 6 steps, pause 3 cycles after 2nd advance, start while busy ignored
        vecs.push_back(mk(1, 1, 0, 0, 0, 6,  2'b01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b11, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1,  2'b01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b11, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 0, 0, 0, 0));
        // 10 steps, stop in RUN after 3 advances; pause ignored in IDLE
        vecs.push_back(mk(1, 1, 0, 0, 0, 10, 2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b11, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0,  2'b11, 2, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  2'b11, 2, 0, 0, 0, 0));
        // resume from held code, stop during HOLD; stop ignored in IDLE
        vecs.push_back(mk(1, 1, 0, 0, 0, 10, 2'b11, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0,  2'b10, 3, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0,  2'b10, 3, 0, 0, 0, 0));
        // 1 step down; start in RUN and in DONE ignored
        vecs.push_back(mk(1, 1, 0, 0, 1, 1,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 5,  2'b11, 2, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 5,  2'b11, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b11, 2, 0, 0, 0, 0));
        // zero-length run
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,  2'b11, 2, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b11, 2, 0, 0, 0, 0));
        // move off 0-reachable position, then reset mid-run after 2 advances
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,  2'b11, 2, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b10, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 5,  2'b10, 3, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b01, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3,  2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1,  2'b00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b01, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  2'b01, 1, 0, 0, 0, 0));

        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.pause  = 1'b0;
        bus.dir    = 1'b0;
        bus.steps  = '0;
        prev_gray  = 2'b00;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v         = vecs[i];
            reset     = v.rst;
            bus.start = v.start;
            bus.stop  = v.stop;
            bus.pause = v.pause;
            bus.dir   = v.dir;
            bus.steps = v.steps;
            exp_q.push_back(v);

            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (bus.gray !== e.gray || bus.bin !== e.bin || bus.busy !== e.busy ||
                bus.done !== e.done || bus.aborted !== e.aborted || bus.wrap !== e.wrap) begin
                errors++;
                $display("FAIL vec%0d got gray=%b bin=%0d busy=%b done=%b aborted=%b wrap=%b want gray=%b bin=%0d busy=%b done=%b aborted=%b wrap=%b",
                         i, bus.gray, bus.bin, bus.busy, bus.done, bus.aborted, bus.wrap,
                         e.gray, e.bin, e.busy, e.done, e.aborted, e.wrap);
            end

            // Registered Gray code never moves more than one bit per edge.
            if (e.rst) begin
                diff = bus.gray ^ prev_gray;
                checks++;
                if ($countones(diff) > 1) begin
                    errors++;
                    $display("FAIL gray_step%0d got %b->%b want at most one bit change",
                             i, prev_gray, bus.gray);
                end
            end
            prev_gray = bus.gray;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
Run controller for a WIDTH-bit Gray-code counter, the same kind as the existing 2-bit q1/q0 Gray counter. A host issues a start command with a step count and direction. The block advances the Gray code one code per clock, supports pause and abort, and signals completion. It owns the Gray register, so downstream logic sees a Gray sequence that never changes more than one bit per cycle.

Parameters:
WIDTH, 2, Gray/binary counter width in bits (>=2)
CNTW, 8, width of step-count field; max run length 2^CNTW-1 steps

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
start  input  1  start command; sampled in IDLE only
stop  input  1  abort current run (RUN or HOLD)
pause  input  1  level; freezes counting while high in RUN
dir  input  1  0 = count up, 1 = count down; latched at start
steps  input  CNTW  number of Gray advances for the run; latched at start
gray  output  WIDTH  registered Gray code, gray = bin ^ (bin >> 1)
bin  output  WIDTH  registered binary equivalent
busy  output  1  high in RUN or HOLD
done  output  1  one-cycle pulse on normal run completion
aborted  output  1  one-cycle pulse when stop ends a run
wrap  output  1  one-cycle pulse on the edge the counter wraps

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; bin=0, gray=0; remaining=0; dir_r=0.
  - busy, done, aborted, wrap all 0.
  - Reset overrides everything, including mid-run.
- States: IDLE, RUN, HOLD, DONE. Encoding is free.
- IDLE:
  - start=1 latches steps into remaining and dir into dir_r.
  - If steps!=0 → RUN; if steps==0 → DONE with no gray change.
  - stop and pause are ignored in IDLE.
- RUN, per edge, priority stop > pause > advance:
  - stop=1 → IDLE; aborted=1 next cycle; gray/bin hold.
  - else pause=1 → HOLD; no advance.
  - else advance: bin ±1 modulo 2^WIDTH, gray updated the same edge, remaining-1. If remaining was 1 → DONE.
- HOLD:
  - stop=1 → IDLE with aborted pulse.
  - else pause=0 → RUN. The first advance occurs on the edge after returning to RUN.
  - gray/bin/remaining frozen.
- DONE:
  - done=1 for exactly this cycle, then unconditional → IDLE.
  - start, stop and pause are ignored in DONE.
- Latency:
  - start sampled at edge k → RUN from k; first gray change at edge k+1.
  - N uninterrupted steps → last change at edge k+N; done high in cycle after edge k+N.
- start while busy or in DONE is ignored (no re-latch).
- gray/bin persist across runs; the next run continues from the current position.
- wrap is registered with the advance:
  - up, bin 2^WIDTH-1→0;
  - down, bin 0→2^WIDTH-1.
- Gray property: successive gray values differ in exactly one bit; no glitch codes are ever registered.
- done and aborted are never both high. wrap may coincide with the final advance; done follows one cycle later.

Test Plan:
- Reset then start, dir=0, steps=4, WIDTH=2 → gray 00→01→11→10→00 on 4 consecutive edges. wrap pulses with the 10→00 edge. done high one cycle after, busy low thereafter.
- From gray=00, start, dir=1, steps=3 → gray 10, 11, 01; wrap on the 00→10 edge; bin 3,2,1; done pulse.
- Run steps=6; hold pause high 3 cycles after 2nd advance → gray frozen 3 cycles, busy stays 1. Total advances still 6, done delayed by exactly the paused cycles.
- Run steps=10; assert stop in RUN after 3 advances, repeat test with stop during HOLD → aborted one-cycle pulse, no done, gray holds last value, state IDLE; a new start resumes from that gray.
- start with steps=0 → no gray change, done pulse next cycle. Also pulse start while busy → ignored, run length unchanged.
- Drive reset low mid-run (after 2 advances) → next edge gray=00, bin=0, all flags 0, IDLE; release, start steps=1 → gray=01, done.
